ddr_ctrl_emu: RTL and testbench

- Synthesizable, parametrised emulator of the Gowin DDR3 controller user interface, backed by on-chip RAM.
- Stands in for controller+DRAM in FPGA bring-up builds and cache regression benches where the real IP is absent or unsimulatable.
- Adds configurable width/depth/latency, byte-mask writes, an outstanding-read limit and sticky protocol-error flags.

---
 rtl/ddr_ctrl_emu.sv | 128 ++++++++++++
 tb/tb_ddr_ctrl_emu.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_ctrl_emu.sv
// RAM-backed stand-in for the DDR3 controller user interface: calibration delay,
// byte-masked writes, fixed-latency in-order reads and sticky protocol-error flags.
module ddr_ctrl_emu #(
  parameter int DATA_W          = 128,
  parameter int ADDR_W          = 28,
  parameter int MEM_DEPTH       = 4096,
  parameter int RD_LATENCY      = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CALIB_CYCLES    = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          ddr_cmd,
  input  logic                ddr_cmd_en,
  input  logic [ADDR_W-1:0]   ddr_addr,
  input  logic [DATA_W-1:0]   ddr_wr_data,
  input  logic [DATA_W/8-1:0] ddr_wr_data_mask,
  input  logic                ddr_wr_data_en,
  output logic                ddr_calib_done,
  output logic                ddr_cmd_ready,
  output logic [DATA_W-1:0]   ddr_rd_data,
  output logic                ddr_rd_data_valid,
  output logic                err_cmd,
  output logic                err_wr_nodata
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int OFF_W     = $clog2(NUM_LANES);
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam int CAL_W     = $clog2(CALIB_CYCLES + 1);
  localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic {ST_CALIB, ST_RUN} state_t;
  typedef struct packed {
    logic             wr;
    logic             rd;
    logic [IDX_W-1:0] idx;
  } ram_req_t;

  state_t                            state, state_nxt;
  logic [CAL_W-1:0]                  cal_cnt, cal_cnt_nxt;
  logic [OUT_W-1:0]                  out_cnt;
  logic [RD_LATENCY:0]               vld_pipe;
  logic [RD_LATENCY-1:1][DATA_W-1:0] dpipe;
  logic [NUM_LANES-1:0][7:0]         ram_q;
  ram_req_t                          req;
  logic                              acc, rd_acc, wr_acc, bad_acc, rsp_now;
  logic                              unused_addr;

  // Ready depends on registered state only, never on ddr_cmd_en.
  assign ddr_cmd_ready = ddr_calib_done && (out_cnt < OUT_W'(MAX_OUTSTANDING));
  assign acc           = ddr_cmd_ready && ddr_cmd_en;
  assign rd_acc        = acc && (ddr_cmd == CMD_RD);
  assign wr_acc        = acc && (ddr_cmd == CMD_WR);
  assign bad_acc       = acc && (ddr_cmd != CMD_RD) && (ddr_cmd != CMD_WR);
  assign rsp_now       = vld_pipe[RD_LATENCY-1];

  assign req.wr  = wr_acc && ddr_wr_data_en;
  assign req.rd  = rd_acc;
  assign req.idx = ddr_addr[OFF_W +: IDX_W];
  assign unused_addr = ^ddr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_CALIB;
      cal_cnt        <= '0;
      ddr_calib_done <= 1'b0;
    end else begin
      state          <= state_nxt;
      cal_cnt        <= cal_cnt_nxt;
      ddr_calib_done <= (state == ST_RUN);
    end
  end

  always_comb begin
    state_nxt   = state;
    cal_cnt_nxt = cal_cnt;
    case (state)
      ST_CALIB: begin
        cal_cnt_nxt = cal_cnt + CAL_W'(1);
        if (cal_cnt == CAL_W'(CALIB_CYCLES - 1)) state_nxt = ST_RUN;
      end
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_CALIB;
    endcase
  end

  // vld_pipe[k] marks a read accepted k edges ago; the top bit is the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe      <= '0;
      out_cnt       <= '0;
      ddr_rd_data   <= '0;
      err_cmd       <= 1'b0;
      err_wr_nodata <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LATENCY-1:0], rd_acc};
      case ({rd_acc, rsp_now})
        2'b10:   out_cnt <= out_cnt + OUT_W'(1);
        2'b01:   out_cnt <= out_cnt - OUT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
      if (rsp_now) ddr_rd_data <= dpipe[RD_LATENCY-1];
      if (bad_acc) err_cmd <= 1'b1;
      if (wr_acc && !ddr_wr_data_en) err_wr_nodata <= 1'b1;
    end
  end

  assign ddr_rd_data_valid = vld_pipe[RD_LATENCY];

  // Data stages carry no reset; vld_pipe qualifies them.
  always_ff @(posedge clk) begin
    dpipe[1] <= ram_q;
    for (int k = 2; k < RD_LATENCY; k++) dpipe[k] <= dpipe[k-1];
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem [MEM_DEPTH];
    logic [7:0] q;
    always_ff @(posedge clk) begin
      if (req.wr && !ddr_wr_data_mask[l]) mem[req.idx] <= ddr_wr_data[l*8 +: 8];
      if (req.rd) q <= mem[req.idx];
    end
    assign ram_q[l] = q;
  end

endmodule

// File: tb/tb_ddr_ctrl_emu.sv
// Randomized bench for ddr_ctrl_emu against a queue/array reference model,
// plus literal expectations for calibration timing, masking, aliasing and limits.
module tb_ddr_ctrl_emu;
  localparam int DATA_W     = 128;
  localparam int ADDR_W     = 28;
  localparam int MEM_DEPTH  = 4096;
  localparam int RD_LATENCY = 3;
  localparam int MAX_OUT    = 2;
  localparam int CALIB      = 100;
  localparam int NB         = DATA_W / 8;
  localparam int NPOOL      = 16;

  logic                clk, rst_n;
  logic [2:0]          ddr_cmd;
  logic                ddr_cmd_en;
  logic [ADDR_W-1:0]   ddr_addr;
  logic [DATA_W-1:0]   ddr_wr_data;
  logic [NB-1:0]       ddr_wr_data_mask;
  logic                ddr_wr_data_en;
  logic                ddr_calib_done, ddr_cmd_ready, ddr_rd_data_valid;
  logic                err_cmd, err_wr_nodata;
  logic [DATA_W-1:0]   ddr_rd_data;

  ddr_ctrl_emu #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH),
    .RD_LATENCY(RD_LATENCY), .MAX_OUTSTANDING(MAX_OUT), .CALIB_CYCLES(CALIB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ddr_cmd(ddr_cmd), .ddr_cmd_en(ddr_cmd_en),
    .ddr_addr(ddr_addr), .ddr_wr_data(ddr_wr_data),
    .ddr_wr_data_mask(ddr_wr_data_mask), .ddr_wr_data_en(ddr_wr_data_en),
    .ddr_calib_done(ddr_calib_done), .ddr_cmd_ready(ddr_cmd_ready),
    .ddr_rd_data(ddr_rd_data), .ddr_rd_data_valid(ddr_rd_data_valid),
    .err_cmd(err_cmd), .err_wr_nodata(err_wr_nodata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory + known-bit map, and a queue of pending responses.
  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] known;
  } resp_t;

  resp_t             q[$];
  logic [DATA_W-1:0] mem_m [MEM_DEPTH];
  logic [DATA_W-1:0] kn_m  [MEM_DEPTH];
  int                since_rel, edge_n;
  bit                done_m, exp_valid, exp_ready, exp_ecmd, exp_enw;
  logic [DATA_W-1:0] exp_data, exp_dmask;
  int                checks, errors;
  int                pool [NPOOL];

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [ADDR_W-1:0] a);
    return int'((a / NB) % MEM_DEPTH);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input int idx);
    int up, off;
    up  = int'($urandom_range(0, (1 << ADDR_W) / (MEM_DEPTH * NB) - 1));
    off = int'($urandom_range(0, NB - 1));
    return ADDR_W'((up * MEM_DEPTH + idx) * NB + off);
  endfunction

  function automatic logic [DATA_W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    q.delete();
    since_rel = 0;
    done_m    = 0;
    exp_valid = 0;
    exp_ready = 0;
    exp_ecmd  = 0;
    exp_enw   = 0;
    exp_data  = '0;
    exp_dmask = '1;
  endtask

  task automatic model_step();
    bit    acc;
    int    i;
    resp_t r;
    edge_n++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc = done_m && (q.size() < MAX_OUT) && ddr_cmd_en;
    exp_valid = 0;
    if (q.size() != 0 && q[0].due == edge_n) begin
      r = q.pop_front();
      exp_valid = 1;
      exp_data  = r.data;
      exp_dmask = r.known;
    end
    if (acc) begin
      i = idx_of(ddr_addr);
      if (ddr_cmd == 3'd0) begin
        if (ddr_wr_data_en) begin
          for (int b = 0; b < NB; b++)
            if (!ddr_wr_data_mask[b]) begin
              mem_m[i][b*8 +: 8] = ddr_wr_data[b*8 +: 8];
              kn_m[i][b*8 +: 8]  = 8'hFF;
            end
        end else exp_enw = 1;
      end else if (ddr_cmd == 3'd1) begin
        r.due   = edge_n + RD_LATENCY;
        r.data  = mem_m[i];
        r.known = kn_m[i];
        q.push_back(r);
      end else exp_ecmd = 1;
    end
    since_rel++;
    done_m    = (since_rel >= CALIB + 1);
    exp_ready = done_m && (q.size() < MAX_OUT);
  endtask

  task automatic compare_all();
    chk("calib_done", DATA_W'(ddr_calib_done), DATA_W'(done_m));
    chk("cmd_ready", DATA_W'(ddr_cmd_ready), DATA_W'(exp_ready));
    chk("rd_valid", DATA_W'(ddr_rd_data_valid), DATA_W'(exp_valid));
    chk("err_cmd", DATA_W'(err_cmd), DATA_W'(exp_ecmd));
    chk("err_wr_nodata", DATA_W'(err_wr_nodata), DATA_W'(exp_enw));
    chk("rd_data", ddr_rd_data & exp_dmask, exp_data & exp_dmask);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_idle();
    ddr_cmd_en = 0; ddr_cmd = 3'd0; ddr_addr = '0;
    ddr_wr_data = '0; ddr_wr_data_mask = '0; ddr_wr_data_en = 0;
  endtask

  task automatic issue(input logic [2:0] c, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [NB-1:0] m,
                       input logic wde);
    ddr_cmd = c; ddr_addr = a; ddr_wr_data = d; ddr_wr_data_mask = m;
    ddr_wr_data_en = wde; ddr_cmd_en = 1;
    tick();
    set_idle();
  endtask

  task automatic rd_word(input logic [ADDR_W-1:0] a);
    int n = 0;
    while (!exp_ready && n < 10) begin tick(); n++; end
    if (n >= 10) chk("ready_timeout", DATA_W'(n), DATA_W'(0));
    issue(3'd1, a, '0, '0, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] pat, a_word;
    bit rdy_seq [9] = '{1, 0, 0, 1, 1, 0, 0, 1, 1};
    checks = 0; errors = 0; edge_n = 0;
    for (int i = 0; i < MEM_DEPTH; i++) begin mem_m[i] = '0; kn_m[i] = '0; end
    for (int i = 0; i < NPOOL; i++) pool[i] = i * 37 + 5;
    set_idle();
    rst_n = 0;
    model_reset();
    repeat (3) tick();
    rst_n = 1;

    // Calibration: done/ready rise exactly 101 clocks after release.
    repeat (CALIB) tick();
    chk("calib_lo_at_100", DATA_W'(ddr_calib_done), DATA_W'(0));
    tick();
    chk("calib_hi_at_101", DATA_W'(ddr_calib_done), DATA_W'(1));
    chk("ready_at_101", DATA_W'(ddr_cmd_ready), DATA_W'(1));

    // Masked write: bytes 4..7 get 0xFF, all others keep the pattern.
    pat = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    issue(3'd0, 28'h40, pat, '0, 1);
    issue(3'd0, 28'h40, '1, 16'hFF0F, 1);
    issue(3'd1, 28'h40, '0, '0, 0);
    tick(); chk("mask_lat_c1", DATA_W'(ddr_rd_data_valid), DATA_W'(0));
    tick(); chk("mask_lat_c2", DATA_W'(ddr_rd_data_valid), DATA_W'(0));
    tick(); chk("mask_lat_c3", DATA_W'(ddr_rd_data_valid), DATA_W'(1));
    chk("mask_data", ddr_rd_data, 128'h0F0E0D0C_0B0A0908_FFFFFFFF_03020100);

    // Read-after-write and aliasing modulo the memory size.
    a_word = rand_word();
    issue(3'd0, 28'h10, a_word, '0, 1);
    issue(3'd1, 28'h10, '0, '0, 0);
    issue(3'd1, 28'h10010, '0, '0, 0);
    tick(); chk("raw_pre", DATA_W'(ddr_rd_data_valid), DATA_W'(0));
    tick(); chk("raw_data", ddr_rd_data, a_word);
    tick(); chk("alias_data", ddr_rd_data, a_word);
    repeat (4) tick();

    for (int i = 0; i < NPOOL; i++) issue(3'd0, addr_of(pool[i]), rand_word(), '0, 1);

    // Outstanding limit with ddr_cmd_en held high on reads.
    ddr_cmd = 3'd1; ddr_cmd_en = 1;
    for (int i = 0; i < 9; i++) begin
      ddr_addr = addr_of(pool[i]);
      tick();
      chk($sformatf("limit_ready_%0d", i), DATA_W'(ddr_cmd_ready), DATA_W'(rdy_seq[i]));
    end
    set_idle();
    repeat (5) tick();

    // Protocol errors: no RAM effect, sticky flags.
    issue(3'b010, addr_of(pool[0]), rand_word(), '0, 1);
    chk("err_cmd_set", DATA_W'(err_cmd), DATA_W'(1));
    issue(3'd0, addr_of(pool[0]), rand_word(), '0, 0);
    chk("err_nodata_set", DATA_W'(err_wr_nodata), DATA_W'(1));
    rd_word(addr_of(pool[0]));
    repeat (5) tick();
    chk("err_cmd_sticky", DATA_W'(err_cmd), DATA_W'(1));

    // Random traffic over the initialised pool.
    for (int n = 0; n < 3000; n++) begin
      int r = int'($urandom_range(0, 15));
      ddr_cmd_en = ($urandom_range(0, 9) < 6);
      ddr_cmd = (r < 7) ? 3'd0 : (r < 15) ? 3'd1 : 3'($urandom_range(2, 7));
      ddr_addr = addr_of(pool[$urandom_range(0, NPOOL - 1)]);
      ddr_wr_data = rand_word();
      ddr_wr_data_mask = ($urandom_range(0, 3) == 0) ? '0 :
                         ($urandom_range(0, 7) == 0) ? '1 : NB'($urandom());
      ddr_wr_data_en = ($urandom_range(0, 7) != 0);
      tick();
    end
    set_idle();
    repeat (6) tick();

    // Reset mid-flight: two accepted reads are discarded, RAM survives.
    issue(3'd1, addr_of(pool[1]), '0, '0, 0);
    issue(3'd1, addr_of(pool[2]), '0, '0, 0);
    tick();
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_valid", DATA_W'(ddr_rd_data_valid), DATA_W'(0));
    chk("rst_data", ddr_rd_data, '0);
    chk("rst_ready", DATA_W'(ddr_cmd_ready), DATA_W'(0));
    chk("rst_errs", DATA_W'({err_cmd, err_wr_nodata, ddr_calib_done}), DATA_W'(0));
    repeat (3) tick();
    rst_n = 1;
    for (int n = 0; n < CALIB; n++) begin
      ddr_cmd_en = 1;
      ddr_cmd = 3'($urandom_range(0, 1));
      ddr_addr = addr_of(pool[$urandom_range(0, NPOOL - 1)]);
      ddr_wr_data = rand_word();
      ddr_wr_data_mask = '0;
      ddr_wr_data_en = 1;
      tick();
    end
    set_idle();
    chk("recal_lo_at_100", DATA_W'(ddr_calib_done), DATA_W'(0));
    tick();
    chk("recal_hi_at_101", DATA_W'(ddr_calib_done), DATA_W'(1));
    for (int i = 0; i < NPOOL; i++) rd_word(addr_of(pool[i]));
    rd_word(28'h40);
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
